// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller for the 5-stage F/D/E/M/W core.
// Produces operand-forwarding selects, per-stage stall/flush and the
// decode-resolved fetch redirect, and sequences load-use bubbles, data-memory
// wait freezes and redirects that must wait for an outstanding fetch.
// Optional feature macro: HAZARD_PERF_EN adds 32-bit performance counters.
module hazard_ctrl #(
   parameter int ADDR_W = 64,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,          // synchronous, active-low
   input  logic [REG_W-1:0]  ra1,
   input  logic [REG_W-1:0]  ra2,
   input  logic              use_ra1,
   input  logic              use_ra2,
   input  logic              branch_takenD,
   input  logic [ADDR_W-1:0] pc_branchD,
   input  logic              validE,
   input  logic              regwriteE,
   input  logic              memreadE,
   input  logic [REG_W-1:0]  dstE,
   input  logic              validM,
   input  logic              regwriteM,
   input  logic              memreadM,
   input  logic [REG_W-1:0]  dstM,
   input  logic              i_wait,
   input  logic              d_wait,
   output logic [1:0]        ac,
   output logic [1:0]        bc,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              pc_redirect,
   output logic [ADDR_W-1:0] pc_target
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       perf_stall,
   output logic [31:0]       perf_loaduse,
   output logic [31:0]       perf_redirect
`endif
);

   // Forward select encoding seen by the decode operand muxes.
   localparam logic [1:0] FWD_RD      = 2'd0;
   localparam logic [1:0] FWD_ALUOUTE = 2'd1;
   localparam logic [1:0] FWD_ALUOUTM = 2'd2;
   localparam logic [1:0] FWD_MEMDATA = 2'd3;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      RPEND = 2'd2
   } state_t;

   state_t            state, state_nx, eff_state;
   logic              pend_valid, pend_valid_nx;
   logic [ADDR_W-1:0] pend_tgt, pend_tgt_nx;
   logic              load_use;

   // Forwarding for one operand: the younger producer in E wins over M.
   // A load still in E cannot forward; that case is the load-use bubble.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] r,
      input logic             use_r,
      input logic             ve, we, me,
      input logic [REG_W-1:0] de,
      input logic             vm, wm, mm,
      input logic [REG_W-1:0] dm
   );
      logic [1:0] sel;
      sel = FWD_RD;
      if (use_r && (r != '0)) begin
         if (ve && we && !me && (de == r))
            sel = FWD_ALUOUTE;
         else if (vm && wm && (dm == r))
            sel = mm ? FWD_MEMDATA : FWD_ALUOUTM;
      end
      return sel;
   endfunction

   // A used non-zero source that matches a load sitting in E.
   function automatic logic lu_hit(
      input logic [REG_W-1:0] r,
      input logic             use_r,
      input logic             ve, we, me,
      input logic [REG_W-1:0] de
   );
      return use_r && (r != '0) && ve && we && me && (de == r);
   endfunction

   // Next-state and output decode. The cycle in which DWAIT releases is
   // evaluated with the rules of the state it returns to, so a branch or
   // load-use sitting in D at release is not lost while D advances.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nx      = state;
      pend_valid_nx = pend_valid;
      pend_tgt_nx   = pend_tgt;
      stallF        = 1'b0;
      stallD        = 1'b0;
      stallE        = 1'b0;
      stallM        = 1'b0;
      flushD        = 1'b0;
      flushE        = 1'b0;
      pc_redirect   = 1'b0;
      pc_target     = '0;

      ac = fwd_sel(ra1, use_ra1, validE, regwriteE, memreadE, dstE,
                   validM, regwriteM, memreadM, dstM);
      bc = fwd_sel(ra2, use_ra2, validE, regwriteE, memreadE, dstE,
                   validM, regwriteM, memreadM, dstM);
      load_use = lu_hit(ra1, use_ra1, validE, regwriteE, memreadE, dstE) ||
                 lu_hit(ra2, use_ra2, validE, regwriteE, memreadE, dstE);

      eff_state = state;
      if ((state == DWAIT) && !d_wait)
         eff_state = pend_valid ? RPEND : RUN;

      unique case (eff_state)
         RUN: begin
            state_nx = RUN;
            if (d_wait) begin
               {stallF, stallD, stallE, stallM} = 4'b1111;
               state_nx = DWAIT;
            end else if (load_use) begin
               stallF = 1'b1;
               stallD = 1'b1;
               flushE = 1'b1;
            end else if (branch_takenD && !i_wait) begin
               pc_redirect = 1'b1;
               pc_target   = pc_branchD;
               flushD      = 1'b1;
            end else if (branch_takenD) begin
               pend_valid_nx = 1'b1;
               pend_tgt_nx   = pc_branchD;
               state_nx      = RPEND;
            end
         end
         DWAIT: begin
            // Only reached here while d_wait is still high.
            {stallF, stallD, stallE, stallM} = 4'b1111;
         end
         RPEND: begin
            if (d_wait) begin
               {stallF, stallD, stallE, stallM} = 4'b1111;
               state_nx = DWAIT;
            end else if (!i_wait) begin
               pc_redirect   = 1'b1;
               pc_target     = pend_tgt;
               flushD        = 1'b1;
               pend_valid_nx = 1'b0;
               state_nx      = RUN;
            end else begin
               stallF   = 1'b1;
               flushD   = 1'b1;
               state_nx = RPEND;
            end
         end
         default: state_nx = RUN;
      endcase

      // While reset is held every control output is quiet.
      if (!reset) begin
         ac          = FWD_RD;
         bc          = FWD_RD;
         stallF      = 1'b0;
         stallD      = 1'b0;
         stallE      = 1'b0;
         stallM      = 1'b0;
         flushD      = 1'b0;
         flushE      = 1'b0;
         pc_redirect = 1'b0;
         pc_target   = '0;
      end
   end

   // State and pending-redirect registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!reset) begin
         state      <= RUN;
         pend_valid <= 1'b0;
         pend_tgt   <= '0;
      end else begin
         state      <= state_nx;
         pend_valid <= pend_valid_nx;
         pend_tgt   <= pend_tgt_nx;
      end
   end

`ifdef HAZARD_PERF_EN
   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_stall    <= '0;
         perf_loaduse  <= '0;
         perf_redirect <= '0;
      end else begin
         if (stallD)      perf_stall    <= perf_stall + 32'd1;
         if (flushE)      perf_loaduse  <= perf_loaduse + 32'd1;
         if (pc_redirect) perf_redirect <= perf_redirect + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 time unit later, well away from the next edge.
module tb_hazard_ctrl;

   localparam int ADDR_W = 64;
   localparam int REG_W  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [REG_W-1:0]  ra1, ra2, dstE, dstM;
   logic              use_ra1, use_ra2, branch_takenD;
   logic [ADDR_W-1:0] pc_branchD;
   logic              validE, regwriteE, memreadE;
   logic              validM, regwriteM, memreadM;
   logic              i_wait, d_wait;
   logic [1:0]        ac, bc;
   logic              stallF, stallD, stallE, stallM, flushD, flushE;
   logic              pc_redirect;
   logic [ADDR_W-1:0] pc_target;
`ifdef HAZARD_PERF_EN
   logic [31:0]       perf_stall, perf_loaduse, perf_redirect;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset(reset),
      .ra1(ra1), .ra2(ra2), .use_ra1(use_ra1), .use_ra2(use_ra2),
      .branch_takenD(branch_takenD), .pc_branchD(pc_branchD),
      .validE(validE), .regwriteE(regwriteE), .memreadE(memreadE), .dstE(dstE),
      .validM(validM), .regwriteM(regwriteM), .memreadM(memreadM), .dstM(dstM),
      .i_wait(i_wait), .d_wait(d_wait),
      .ac(ac), .bc(bc),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE),
      .pc_redirect(pc_redirect), .pc_target(pc_target)
`ifdef HAZARD_PERF_EN
      , .perf_stall(perf_stall), .perf_loaduse(perf_loaduse), .perf_redirect(perf_redirect)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ra1 = '0; ra2 = '0; use_ra1 = 1'b0; use_ra2 = 1'b0;
      branch_takenD = 1'b0; pc_branchD = '0;
      validE = 1'b0; regwriteE = 1'b0; memreadE = 1'b0; dstE = '0;
      validM = 1'b0; regwriteM = 1'b0; memreadM = 1'b0; dstM = '0;
      i_wait = 1'b0; d_wait = 1'b0;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      tick();

      // Reset held: outputs quiet even with an active branch and forward match.
      branch_takenD = 1'b1; pc_branchD = 64'h1111; validE = 1'b1; regwriteE = 1'b1;
      dstE = 5'd5; ra1 = 5'd5; use_ra1 = 1'b1; d_wait = 1'b1;
      #1;
      check("rst_redirect", 64'(pc_redirect), 64'd0);
      check("rst_target",   pc_target,        64'd0);
      check("rst_ac",       64'(ac),          64'd0);
      check("rst_stalls",   64'({stallF, stallD, stallE, stallM, flushD, flushE}), 64'd0);
      tick();
      idle();
      reset = 1'b1;

      // addi x5 in E, D reads x5 -> ALUOUTE, no stall.
      validE = 1'b1; regwriteE = 1'b1; dstE = 5'd5; ra1 = 5'd5; use_ra1 = 1'b1;
      #1;
      check("fwd_e_ac",    64'(ac),     64'd1);
      check("fwd_e_stall", 64'(stallD), 64'd0);
      // x0 never forwards.
      dstE = 5'd0; ra1 = 5'd0;
      #1;
      check("fwd_x0_ac", 64'(ac), 64'd0);
      // Operand not used -> RD.
      dstE = 5'd6; ra1 = 5'd6; use_ra1 = 1'b0;
      #1;
      check("fwd_unused_ac", 64'(ac), 64'd0);
      tick();
      idle();

      // M-stage producers: ALU result, then load, then E overrides M.
      validM = 1'b1; regwriteM = 1'b1; dstM = 5'd3; ra2 = 5'd3; use_ra2 = 1'b1;
      #1;
      check("fwd_m_alu_bc", 64'(bc), 64'd2);
      memreadM = 1'b1;
      #1;
      check("fwd_m_mem_bc", 64'(bc), 64'd3);
      validE = 1'b1; regwriteE = 1'b1; dstE = 5'd3;
      #1;
      check("fwd_e_prio_bc", 64'(bc), 64'd1);
      tick();
      idle();

      // Load-use: ld x7 in E, D reads x7; a simultaneous branch is ignored.
      validE = 1'b1; regwriteE = 1'b1; memreadE = 1'b1; dstE = 5'd7;
      ra2 = 5'd7; use_ra2 = 1'b1; branch_takenD = 1'b1; pc_branchD = 64'h2000;
      #1;
      check("lu_stalls",   64'({stallF, stallD, flushE}), 64'b111);
      check("lu_noredir",  64'(pc_redirect), 64'd0);
      check("lu_bc",       64'(bc), 64'd0);
      tick();
      idle();
      validM = 1'b1; regwriteM = 1'b1; memreadM = 1'b1; dstM = 5'd7;
      ra2 = 5'd7; use_ra2 = 1'b1;
      #1;
      check("lu_next_bc",    64'(bc), 64'd3);
      check("lu_next_stall", 64'({stallF, stallD, flushE}), 64'b000);
      tick();
      idle();

      // Immediate redirect with fetch idle.
      branch_takenD = 1'b1; pc_branchD = 64'h8000_0040;
      #1;
      check("br_redirect", 64'(pc_redirect), 64'd1);
      check("br_target",   pc_target,        64'h8000_0040);
      check("br_flushD",   64'(flushD),      64'd1);
      tick();
      idle();
      #1;
      check("br_pulse_end", 64'(pc_redirect), 64'd0);
      tick();

      // Redirect deferred by an outstanding fetch.
      branch_takenD = 1'b1; pc_branchD = 64'h1234; i_wait = 1'b1;
      #1;
      check("pend_latch_redir", 64'(pc_redirect), 64'd0);
      check("pend_latch_flush", 64'({stallF, flushD}), 64'b00);
      tick();
      idle();
      i_wait = 1'b1; pc_branchD = 64'hDEAD;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("pend_wait_sf_fd", 64'({stallF, flushD, pc_redirect}), 64'b110);
         tick();
      end
      i_wait = 1'b0;
      #1;
      check("pend_redirect", 64'(pc_redirect), 64'd1);
      check("pend_target",   pc_target,        64'h1234);
      check("pend_flushD",   64'(flushD),      64'd1);
      tick();
      #1;
      check("pend_back_run", 64'({pc_redirect, stallF, flushD}), 64'b000);
      tick();

      // d_wait alongside branch and load-use in RUN: freeze only.
      validE = 1'b1; regwriteE = 1'b1; memreadE = 1'b1; dstE = 5'd9;
      ra1 = 5'd9; use_ra1 = 1'b1; branch_takenD = 1'b1; pc_branchD = 64'h40; d_wait = 1'b1;
      #1;
      check("dw_run_stalls", 64'({stallF, stallD, stallE, stallM, flushE, pc_redirect}), 64'b111100);
      tick();
      idle();
      #1;
      check("dw_release", 64'({stallF, stallD, stallE, stallM}), 64'b0000);
      tick();

      // d_wait for 4 cycles arriving in RPEND, then the redirect completes.
      branch_takenD = 1'b1; pc_branchD = 64'hABCD; i_wait = 1'b1;
      tick();
      idle();
      i_wait = 1'b1; d_wait = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rp_dw_stalls", 64'({stallF, stallD, stallE, stallM, pc_redirect}), 64'b11110);
         tick();
      end
      d_wait = 1'b0;
      #1;
      check("rp_dw_release", 64'({stallE, stallM, pc_redirect}), 64'b000);
      tick();
      i_wait = 1'b0;
      #1;
      check("rp_dw_redirect", 64'(pc_redirect), 64'd1);
      check("rp_dw_target",   pc_target,        64'hABCD);
      tick();
      #1;
      check("rp_dw_pulse_end", 64'(pc_redirect), 64'd0);
      tick();

      // Reset while in DWAIT with a pending target discards it.
      branch_takenD = 1'b1; pc_branchD = 64'h5555; i_wait = 1'b1;
      tick();
      idle();
      i_wait = 1'b1; d_wait = 1'b1;
      tick();
      #1;
      check("rst_dw_stallD", 64'(stallD), 64'd1);
      reset = 1'b0;
      #1;
      check("rst_dw_quiet", 64'({stallF, stallD, stallE, stallM, flushD, pc_redirect}), 64'd0);
      tick();
      reset = 1'b1; d_wait = 1'b0; i_wait = 1'b0;
      #1;
      check("rst_dw_lost", 64'({pc_redirect, stallF, flushD}), 64'b000);
      check("rst_dw_target", pc_target, 64'd0);
      tick();

`ifdef HAZARD_PERF_EN
      // One load-use bubble and two redirects since the last reset.
      validE = 1'b1; regwriteE = 1'b1; memreadE = 1'b1; dstE = 5'd4;
      ra1 = 5'd4; use_ra1 = 1'b1;
      tick();
      idle();
      branch_takenD = 1'b1; pc_branchD = 64'h100;
      tick();
      idle();
      tick();
      branch_takenD = 1'b1; pc_branchD = 64'h200;
      tick();
      idle();
      #1;
      check("perf_loaduse",  64'(perf_loaduse),  64'd1);
      check("perf_redirect", 64'(perf_redirect), 64'd2);
      check("perf_stall",    64'(perf_stall),    64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
